adder_result_fifo: RTL and testbench

- Result buffer placed directly downstream of the five-stage pipelined adder.
- Captures every 17-bit sum the adder presents on its valid strobe. The adder has no backpressure, so capture is unconditional.
- Presents the sums in order to the consumer over a valid/ready handshake.
- Gives the operand issuer an almost_full warning sized for the adder's in-flight results, and records any sums dropped on overflow.

---
 rtl/adder_result_fifo.sv | 89 ++++++++
 tb/tb_adder_result_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// rtl/adder_result_fifo.sv - first-word-fall-through result buffer behind the pipelined adder
`timescale 1ns/1ps
module adder_result_fifo #(
   parameter int WIDTH        = 17,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_i,
   input  logic [WIDTH-1:0]           data_in,
   output logic                       valid_o,
   output logic [WIDTH-1:0]           data_out,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt,
   input  logic                       clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             push;
   logic             pop;
   logic             drop;

   // A pop frees the slot this cycle, so a full FIFO still accepts a push alongside it.
   always_comb begin
      pop  = valid_o && ready_i;
      push = valid_i && ((count != FULL_LVL) || pop);
      drop = valid_i && !push;
   end

   assign valid_o     = (count != '0);
   assign data_out    = mem[rd_ptr];
   assign almost_full = (count >= AFULL_LVL);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A drop in the same cycle as clr_ovf wins, so the fresh loss is never hidden.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf) begin
            drop_cnt <= 8'd1;
         end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end
   end

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb/tb_adder_result_fifo.sv - directed self-checking bench for adder_result_fifo
`timescale 1ns/1ps
module tb_adder_result_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [16:0] data_in = '0;
   logic        valid_o;
   logic [16:0] data_out;
   logic        ready_i = 1'b0;
   logic [3:0]  count;
   logic        almost_full;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        clr_ovf = 1'b0;

   int checks = 0;
   int errors = 0;

   adder_result_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .data_in     (data_in),
      .valid_o     (valid_o),
      .data_out    (data_out),
      .ready_i     (ready_i),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt),
      .clr_ovf     (clr_ovf)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 1'b0;
      ready_i = 1'b0;
      clr_ovf = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 12; i++) begin
         rst     = 1'b0;
         valid_i = 1'($urandom_range(0, 1));
         ready_i = 1'($urandom_range(0, 1));
         data_in = 17'($urandom);
         step();
      end
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %0b expected 0", valid_o); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %0b expected 0", almost_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_ordered_drain();
      logic [16:0] exp_vals [3];
      exp_vals[0] = 17'h00005;
      exp_vals[1] = 17'h1FFFF;
      exp_vals[2] = 17'h10000;
      idle();
      for (int i = 0; i < 3; i++) begin
         valid_i = 1'b1;
         data_in = exp_vals[i];
         step();
      end
      valid_i = 1'b0;
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL drain_count: got %0d expected 3", count); end
      checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL drain_almost_full: got %0b expected 1", almost_full); end
      checks++; if (data_out !== 17'h00005) begin errors++; $display("FAIL drain_head: got %05h expected 00005", data_out); end
      step();
      checks++; if (data_out !== 17'h00005) begin errors++; $display("FAIL drain_head_hold: got %05h expected 00005", data_out); end
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (valid_o !== 1'b1 || data_out !== exp_vals[i]) begin errors++; $display("FAIL drain_data[%0d]: got v=%0b d=%05h expected v=1 d=%05h", i, valid_o, data_out, exp_vals[i]); end
         step();
      end
      ready_i = 1'b0;
      checks++; if (valid_o !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL drain_empty: got v=%0b count=%0d expected v=0 count=0", valid_o, count); end
   endtask

   task automatic test_overflow();
      idle();
      for (int i = 1; i <= 10; i++) begin
         valid_i = 1'b1;
         data_in = 17'(i);
         step();
      end
      valid_i = 1'b0;
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
      ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checks++; if (valid_o !== 1'b1 || data_out !== 17'(i)) begin errors++; $display("FAIL ovf_drain[%0d]: got v=%0b d=%0d expected v=1 d=%0d", i, valid_o, data_out, i); end
         step();
      end
      ready_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty: got %0b expected 0", valid_o); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clear: got ovf=%0b cnt=%0d expected ovf=0 cnt=0", overflow, drop_cnt); end
   endtask

   task automatic test_full_push_pop();
      idle();
      for (int i = 1; i <= 8; i++) begin
         valid_i = 1'b1;
         data_in = 17'(i);
         step();
      end
      valid_i = 1'b1;
      data_in = 17'd9;
      ready_i = 1'b1;
      step();
      valid_i = 1'b0;
      ready_i = 1'b0;
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpp_count: got %0d expected 8", count); end
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL fullpp_no_drop: got ovf=%0b cnt=%0d expected 0/0", overflow, drop_cnt); end
      ready_i = 1'b1;
      for (int i = 2; i <= 9; i++) begin
         checks++; if (valid_o !== 1'b1 || data_out !== 17'(i)) begin errors++; $display("FAIL fullpp_drain[%0d]: got v=%0b d=%0d expected v=1 d=%0d", i, valid_o, data_out, i); end
         step();
      end
      ready_i = 1'b0;
      checks++; if (valid_o !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL fullpp_empty: got v=%0b count=%0d expected 0/0", valid_o, count); end
   endtask

   task automatic test_wrap();
      idle();
      ready_i = 1'b1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL wrap_start_empty: got %0b expected 0", valid_o); end
      for (int k = 0; k <= 20; k++) begin
         valid_i = (k < 20);
         data_in = 17'(100 + k);
         if (k > 0) begin
            checks++; if (valid_o !== 1'b1 || data_out !== 17'(100 + k - 1)) begin errors++; $display("FAIL wrap_data[%0d]: got v=%0b d=%0d expected v=1 d=%0d", k, valid_o, data_out, 100 + k - 1); end
         end
         checks++; if (count > 4'd1) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected <=1", k, count); end
         step();
      end
      idle();
      checks++; if (valid_o !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL wrap_end: got v=%0b count=%0d expected 0/0", valid_o, count); end
   endtask

   task automatic test_saturate_and_clr_race();
      idle();
      valid_i = 1'b1;
      for (int i = 0; i < 270; i++) begin
         data_in = 17'(i);
         step();
      end
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop_cnt: got %0d expected 255", drop_cnt); end
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL sat_count: got %0d expected 8", count); end
      checks++; if (data_out !== 17'd0) begin errors++; $display("FAIL sat_head: got %0d expected 0", data_out); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      valid_i = 1'b0;
      checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_race: got ovf=%0b cnt=%0d expected ovf=1 cnt=1", overflow, drop_cnt); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_plain: got ovf=%0b cnt=%0d expected 0/0", overflow, drop_cnt); end
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL clr_keeps_data: got %0d expected 8", count); end
   endtask

   task automatic test_reset_mid();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         data_in = 17'(40 + i);
         step();
      end
      valid_i = 1'b0;
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 5", count); end
      rst     = 1'b1;
      valid_i = 1'b1;
      ready_i = 1'b1;
      data_in = 17'h0ABCD;
      step();
      idle();
      checks++; if (count !== 4'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_cleared: got count=%0d v=%0b expected 0/0", count, valid_o); end
      step();
      checks++; if (count !== 4'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got count=%0d v=%0b expected 0/0", count, valid_o); end
   endtask

   initial begin
      test_reset();
      test_ordered_drain();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_saturate_and_clr_race();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
